// File: rtl/ias_pkg.sv
// Shared definitions for the IAS memory subsystem: word geometry,
// arbiter state encoding and port-owner codes.
package ias_pkg;

  localparam int ADDR_W = 12;  // 4096-word main memory
  localparam int DATA_W = 40;  // IAS word

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_IO  = 1'b1;

endpackage

// File: rtl/ias_starve_counter.sv
// Starvation guard for the I/O port: counts consecutive CPU grants taken
// while the I/O loader is waiting, and raises io_priority once the CPU has
// used up its allowed burst.
module ias_starve_counter #(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic idle,
  input  logic cpu_grant,
  input  logic io_grant,
  input  logic io_req,
  output logic io_priority
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_CPU_BURST);

  logic [3:0] streak;

  // Streak register: clear when I/O is served or not waiting, count CPU
  // grants that overtook a waiting I/O request, saturate at the burst limit.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) begin
      streak <= '0;
    end else if (io_grant) begin
      streak <= '0;
    end else if (idle && !io_req) begin
      streak <= '0;
    end else if (cpu_grant && io_req && (streak != MAX_STREAK)) begin
      streak <= streak + 4'd1;
    end
  end

  assign io_priority = (streak == MAX_STREAK);

endmodule

// File: rtl/ias_mem_arbiter.sv
// Two-port arbiter for the IAS main memory. The CPU has fixed priority,
// bounded by a starvation guard for the I/O loader. Each grant runs a
// four-state registered transaction against a synchronous single-port
// memory with one cycle of read latency.
module ias_mem_arbiter
  import ias_pkg::*;
#(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // I/O loader port
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              busy,
  output logic              owner
);

  arb_state_t state;
  logic       io_priority;
  logic       sel_io;
  logic       grant_any;
  logic       cpu_grant;
  logic       io_grant;

  // Winner selection, only acted on while IDLE.
  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can be
    // inferred; any future conditional logic must keep a default first.
    sel_io    = io_req && (!cpu_req || io_priority);
    grant_any = (state == ST_IDLE) && (cpu_req || io_req);
    cpu_grant = grant_any && !sel_io;
    io_grant  = grant_any && sel_io;
  end

  ias_starve_counter #(
    .MAX_CPU_BURST (MAX_CPU_BURST)
  ) u_starve (
    .clk         (clk),
    .reset_n     (reset_n),
    .idle        (state == ST_IDLE),
    .cpu_grant   (cpu_grant),
    .io_grant    (io_grant),
    .io_req      (io_req),
    .io_priority (io_priority)
  );

  // Transaction FSM with all outputs registered; mem_we stays latched for
  // the whole transaction so WAIT knows whether to capture read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      io_ack    <= 1'b0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
      busy      <= 1'b0;
      owner     <= OWNER_CPU;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner     <= sel_io ? OWNER_IO : OWNER_CPU;
            mem_en    <= 1'b1;
            mem_we    <= sel_io ? io_we    : cpu_we;
            mem_addr  <= sel_io ? io_addr  : cpu_addr;
            mem_wdata <= sel_io ? io_wdata : cpu_wdata;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (owner == OWNER_IO) begin
            if (!mem_we) io_rdata <= mem_rdata;
            io_ack <= 1'b1;
          end else begin
            if (!mem_we) cpu_rdata <= mem_rdata;
            cpu_ack <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          cpu_ack <= 1'b0;
          io_ack  <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
